// File: rtl/pixel_stream_packer_pkg.sv
// pixel_stream_packer_pkg
// Shared pixel/stream definitions for the shading-output packer.
//   rgb24_t        : packed RGB888 pixel, r in [23:16], g in [15:8], b in [7:0]
//   AXIS_PAD       : filler byte placed above the pixel in a 32-bit beat
//   axis_pack_rgb  : builds the 32-bit AXI4-Stream word {pad, r, g, b}
package pixel_stream_packer_pkg;

  localparam logic [7:0] AXIS_PAD = 8'h00;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  function automatic logic [31:0] axis_pack_rgb(rgb24_t pix);
    return {AXIS_PAD, pix.r, pix.g, pix.b};
  endfunction

endpackage

// File: rtl/pixel_stream_packer_sync_fifo.sv
// sync_fifo
// Single-clock first-word-fall-through FIFO: the head entry is visible on
// rd_data whenever empty is low, and rd_en consumes it.
// Ports:
//   clk, rst_n      : rising-edge clock, synchronous active-low reset
//   wr_en, wr_data  : push request and data (ignored while full)
//   rd_en, rd_data  : pop request (ignored while empty) and head entry
//   full, empty     : occupancy flags from the registered count
//   level           : current occupancy, 0..DEPTH
module sync_fifo
  import pixel_stream_packer_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doWrite, doRead;

  assign full    = (count_q == FULL_LEVEL);
  assign empty   = (count_q == '0);
  assign doWrite = wr_en && !full;
  assign doRead  = rd_en && !empty;
  assign rd_data = mem_q[rdPtr_q];
  assign level   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // carries the extra bit that distinguishes full from empty.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doWrite) wrPtr_d = wrPtr_q + AW'(1);
    if (doRead)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doWrite, doRead})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale entries are never visible because the
  // count gates everything downstream.
  always_ff @(posedge clk) begin
    if (rst_n && doWrite) begin
      mem_q[wrPtr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer
// Accepts valid-qualified RGB888 pixels from the shading pipeline, buffers
// them in a small FWFT FIFO and emits them as an AXI4-Stream video stream
// with start-of-frame (tuser) and end-of-line (tlast) from raster counters.
// Ports:
//   clk, rst_n                 : rising-edge clock, synchronous active-low reset
//   valid_in, pixel_in         : upstream pixel, accepted when valid_in && ready_out
//   ready_out                  : FIFO not full
//   m_axis_tdata/tvalid/tready : output beat {8'h00, R, G, B} and handshake
//   m_axis_tuser, m_axis_tlast : first pixel of frame / last pixel of line
//   frame_done                 : one-cycle pulse after the last beat of a frame
//   fifo_level                 : FIFO occupancy (debug)
module pixel_stream_packer
  import pixel_stream_packer_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_WIDTH  = 24,
  parameter int AXIS_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic [PIX_WIDTH-1:0]        pixel_in,
  output logic                        ready_out,
  output logic [AXIS_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  // Counter widths are clamped to 1 so a single-line frame still elaborates.
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [PIX_WIDTH-1:0] fifoData;
  logic                 fifoFull, fifoEmpty;
  logic                 push, pop;
  logic                 lineEnd, frameEnd;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 frameDone_q, frameDone_d;

  assign ready_out     = !fifoFull;
  assign push          = valid_in && !fifoFull;
  assign m_axis_tvalid = !fifoEmpty;
  assign pop           = m_axis_tvalid && m_axis_tready;

  sync_fifo #(
    .WIDTH (PIX_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (pixel_in),
    .rd_en   (pop),
    .rd_data (fifoData),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .level   (fifo_level)
  );

  assign lineEnd  = (x_q == X_LAST);
  assign frameEnd = lineEnd && (y_q == Y_LAST);

  // Sideband and data are forced to zero when no beat is offered. While a
  // beat stalls, the FIFO head and counters do not move, so all of these
  // stay constant until the handshake.
  assign m_axis_tdata = m_axis_tvalid ? AXIS_WIDTH'(axis_pack_rgb(rgb24_t'(fifoData))) : '0;
  assign m_axis_tuser = m_axis_tvalid && (x_q == '0) && (y_q == '0);
  assign m_axis_tlast = m_axis_tvalid && lineEnd;

  // Raster position advances only on an accepted output beat.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    frameDone_d = 1'b0;
    if (pop) begin
      if (lineEnd) begin
        x_d = '0;
        y_d = frameEnd ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      frameDone_d = frameEnd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      frameDone_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb_pixel_stream_packer
// Self-checking bench for pixel_stream_packer with a 4x2 frame and a
// 4-entry FIFO. A queue-based model predicts every output on every cycle;
// directed scenarios add literal expectations on top.
module tb_pixel_stream_packer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int D     = 4;
  localparam int FRAME = W * H;

  logic        clk           = 1'b0;
  logic        rst_n         = 1'b0;
  logic        valid_in      = 1'b0;
  logic [23:0] pixel_in      = 24'h0;
  logic        ready_out;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        frame_done;
  logic [2:0]  fifo_level;

  int compared   = 0;
  int mismatched = 0;

  // Stimulus control
  logic [23:0] srcQ[$];
  bit          driverEn     = 1'b0;
  bit          holdValid    = 1'b0;
  logic [23:0] holdPixel    = 24'h0;
  bit          treadyRandom = 1'b0;
  logic        treadyFixed  = 1'b0;

  // Reference model state
  logic [23:0] modelQ[$];
  int          modelBeat = 0;
  bit          modelDone = 1'b0;
  bit          checkEn   = 1'b0;

  // Stall tracking
  bit          prevStall = 1'b0;
  logic [31:0] prevData;
  logic        prevUser, prevLast;

  // Directed-scenario scratch
  logic [31:0] got[$];
  logic [23:0] sent[$];
  bit          found;
  int          beats, doneCount, doneAtBeat, tlastCount, tuserCount, firstCyc, lastCyc, cyc;
  logic        tuserBeat9;

  pixel_stream_packer #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_DEPTH (D),
    .PIX_WIDTH  (24),
    .AXIS_WIDTH (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .pixel_in      (pixel_in),
    .ready_out     (ready_out),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Main-sequence step: 2 time units after the edge, after both drivers.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Model: the FIFO is a queue, the raster position is the beat count
  // modulo the frame size.
  task automatic updateModel();
    bit canPush, doPop;
    if (!rst_n) begin
      modelQ.delete();
      modelBeat = 0;
      modelDone = 1'b0;
      checkEn   = 1'b1;
    end else begin
      canPush   = valid_in && (modelQ.size() < D);
      doPop     = (modelQ.size() > 0) && m_axis_tready;
      modelDone = doPop && ((modelBeat % FRAME) == FRAME - 1);
      if (doPop) begin
        void'(modelQ.pop_front());
        modelBeat++;
      end
      if (canPush) modelQ.push_back(pixel_in);
    end
  endtask

  initial forever begin
    @(posedge clk);
    updateModel();
  end

  // Every-cycle compare against the model, plus AXI hold-during-stall.
  initial forever begin
    bit expValid;
    @(negedge clk);
    if (checkEn) begin
      expValid = (modelQ.size() > 0);
      checkOutput("ready_out",  {31'b0, ready_out},     {31'b0, modelQ.size() < D});
      checkOutput("fifo_level", {29'b0, fifo_level},    modelQ.size());
      checkOutput("tvalid",     {31'b0, m_axis_tvalid}, {31'b0, expValid});
      checkOutput("tdata",      m_axis_tdata,           expValid ? {8'h00, modelQ[0]} : 32'h0);
      checkOutput("tuser",      {31'b0, m_axis_tuser},  {31'b0, expValid && ((modelBeat % FRAME) == 0)});
      checkOutput("tlast",      {31'b0, m_axis_tlast},  {31'b0, expValid && ((modelBeat % W) == W - 1)});
      checkOutput("frame_done", {31'b0, frame_done},    {31'b0, modelDone});
      if (prevStall) begin
        checkOutput("stall_tvalid", {31'b0, m_axis_tvalid}, 32'h1);
        checkOutput("stall_tdata",  m_axis_tdata,           prevData);
        checkOutput("stall_tuser",  {31'b0, m_axis_tuser},  {31'b0, prevUser});
        checkOutput("stall_tlast",  {31'b0, m_axis_tlast},  {31'b0, prevLast});
      end
      prevStall = rst_n && m_axis_tvalid && !m_axis_tready;
      prevData  = m_axis_tdata;
      prevUser  = m_axis_tuser;
      prevLast  = m_axis_tlast;
    end
  end

  // Upstream driver: presents srcQ head and holds it until accepted.
  initial forever begin
    bit wasAccepted;
    @(negedge clk);
    wasAccepted = driverEn && rst_n && valid_in && ready_out;
    @(posedge clk);
    #1;
    if (!driverEn) begin
      valid_in = holdValid;
      pixel_in = holdPixel;
    end else begin
      if (wasAccepted && srcQ.size() > 0) void'(srcQ.pop_front());
      if (srcQ.size() > 0) begin
        valid_in = 1'b1;
        pixel_in = srcQ[0];
      end else begin
        valid_in = 1'b0;
      end
    end
  end

  // Downstream tready driver.
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = treadyRandom ? 1'($urandom_range(0, 1)) : treadyFixed;
  end

  task automatic resetDut();
    driverEn  = 1'b0;
    holdValid = 1'b0;
    srcQ.delete();
    rst_n = 1'b0;
    repeat (2) nextCycle();
    rst_n    = 1'b1;
    driverEn = 1'b1;
  endtask

  task automatic waitIdle(input int maxCycles, input string name);
    int n = 0;
    while ((srcQ.size() > 0 || modelQ.size() > 0 || valid_in) && n < maxCycles) begin
      nextCycle();
      n++;
    end
    checkOutput(name, {31'b0, n >= maxCycles}, 32'h0);
  endtask

  task automatic applyStimulus();
    // 1: reset with valid_in held high
    rst_n     = 1'b0;
    holdValid = 1'b1;
    holdPixel = 24'h123456;
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("t1_ready",  {31'b0, ready_out},     32'h1);
    checkOutput("t1_tvalid", {31'b0, m_axis_tvalid}, 32'h0);
    checkOutput("t1_tuser",  {31'b0, m_axis_tuser},  32'h0);
    checkOutput("t1_tlast",  {31'b0, m_axis_tlast},  32'h0);
    checkOutput("t1_level",  {29'b0, fifo_level},    32'h0);
    checkOutput("t1_tdata",  m_axis_tdata,           32'h0);
    holdValid = 1'b0;
    repeat (2) nextCycle();
    rst_n = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("t1_nothing_captured", {29'b0, fifo_level}, 32'h0);

    // 2: single pixel
    treadyFixed = 1'b1;
    driverEn    = 1'b1;
    nextCycle();
    srcQ.push_back(24'hFF8040);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) found = 1'b1;
    end
    checkOutput("t2_seen",  {31'b0, found},        32'h1);
    checkOutput("t2_tdata", m_axis_tdata,          32'h00FF8040);
    checkOutput("t2_tuser", {31'b0, m_axis_tuser}, 32'h1);
    checkOutput("t2_tlast", {31'b0, m_axis_tlast}, 32'h0);
    @(negedge clk);
    checkOutput("t2_tvalid_after", {31'b0, m_axis_tvalid}, 32'h0);
    waitIdle(20, "t2_timeout");

    // 3: backpressure with 5 pixels
    treadyFixed = 1'b0;
    resetDut();
    for (int i = 0; i < 5; i++) srcQ.push_back(24'hA00000 + 24'(i));
    repeat (8) nextCycle();
    @(negedge clk);
    checkOutput("t3_level", {29'b0, fifo_level}, 32'h4);
    checkOutput("t3_ready", {31'b0, ready_out},  32'h0);
    checkOutput("t3_head",  m_axis_tdata,        32'h00A00000);
    checkOutput("t3_held",  {8'h0, pixel_in},    32'h00A00004);
    treadyFixed = 1'b1;
    got.delete();
    cyc = 0;
    firstCyc = 0;
    lastCyc = 0;
    while (got.size() < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (got.size() == 0) firstCyc = cyc;
        lastCyc = cyc;
        got.push_back(m_axis_tdata);
      end
    end
    checkOutput("t3_count", got.size(), 32'h5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      checkOutput("t3_order", got[i], 32'h00A00000 + i);
    checkOutput("t3_back_to_back", lastCyc - firstCyc, 32'h4);
    waitIdle(20, "t3_timeout");

    // 4: full frame plus one beat
    resetDut();
    for (int i = 1; i <= 9; i++) srcQ.push_back(24'(i));
    beats = 0; doneCount = 0; doneAtBeat = -1; tlastCount = 0; tuserCount = 0;
    tuserBeat9 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) begin
        doneCount++;
        doneAtBeat = beats;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        if (m_axis_tlast) tlastCount++;
        if (m_axis_tuser) tuserCount++;
        if (beats == 9) tuserBeat9 = m_axis_tuser;
        if (m_axis_tlast && beats != 4 && beats != 8)
          checkOutput("t4_tlast_beat", beats, 32'h4);
      end
    end
    checkOutput("t4_beats",      beats,               32'h9);
    checkOutput("t4_done_count", doneCount,           32'h1);
    checkOutput("t4_done_after", doneAtBeat,          32'h8);
    checkOutput("t4_tlast_cnt",  tlastCount,          32'h2);
    checkOutput("t4_tuser_cnt",  tuserCount,          32'h2);
    checkOutput("t4_tuser_b9",   {31'b0, tuserBeat9}, 32'h1);

    // 5: random tready over three frames, scoreboard on order
    resetDut();
    treadyRandom = 1'b1;
    sent.delete();
    got.delete();
    for (int i = 0; i < 3 * FRAME; i++) begin
      sent.push_back(24'($urandom()));
      srcQ.push_back(sent[i]);
    end
    cyc = 0;
    while (got.size() < 3 * FRAME && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
    end
    checkOutput("t5_count", got.size(), 3 * FRAME);
    for (int i = 0; i < 3 * FRAME && i < got.size(); i++)
      checkOutput("t5_order", got[i], {8'h00, sent[i]});
    treadyRandom = 1'b0;
    waitIdle(40, "t5_timeout");

    // 6: reset after three beats
    resetDut();
    for (int i = 0; i < 5; i++) srcQ.push_back(24'h500000 + 24'(i));
    cyc = 0;
    while (modelBeat < 3 && cyc < 40) begin
      nextCycle();
      cyc++;
    end
    checkOutput("t6_reach3", modelBeat, 32'h3);
    resetDut();
    @(negedge clk);
    checkOutput("t6_cleared", {29'b0, fifo_level}, 32'h0);
    nextCycle();
    srcQ.push_back(24'hABCDEF);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) found = 1'b1;
    end
    checkOutput("t6_seen",  {31'b0, found},        32'h1);
    checkOutput("t6_tdata", m_axis_tdata,          32'h00ABCDEF);
    checkOutput("t6_tuser", {31'b0, m_axis_tuser}, 32'h1);
    checkOutput("t6_tlast", {31'b0, m_axis_tlast}, 32'h0);
    waitIdle(20, "t6_timeout");
  endtask

  initial begin
    applyStimulus();
    repeat (2) nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
